npc_spawn_scheduler: RTL and testbench
======================================

Name: npc_spawn_scheduler

Overview:
- Game-level sequencer for the NPC traffic in MonacoGP.
- Owns the run/pause/crash state and paces NPC spawns with a difficulty-scaled interval.
- Shares one randnum source across NUM_NPC car instances: grants each spawn to one idle car slot (round-robin) and supplies a folded start X and direction.
- Sits between keyboard/LFSR/collision logic and the array of NPC car instances.

Parameters:
- NUM_NPC, 4, number of NPC car slots (2..8)
- NPC_X_MIN, 48, leftmost legal spawn X
- NPC_X_MAX, 232, rightmost legal spawn X
- SPAWN_INIT, 120, initial frames between spawns
- SPAWN_MIN, 30, floor of spawn interval
- INTERVAL_STEP, 10, interval reduction per level-up
- LEVEL_STEP, 8, spawns per level-up
- CRASH_FRAMES, 90, frames frozen after collision
- LANE_GUARD, 24, minimum X separation from previous spawn (optional feature only)

Ports:
- frame_clk  in  1  frame-rate clock, all logic on rising edge
- reset  in  1  asynchronous active-high reset
- keycode  in  8  current key; 8'h15 = start, 8'h13 = pause toggle
- randnum  in  8  free-running random value
- npc_active  in  NUM_NPC  per-slot "car on screen" flag from the car instances
- collision  in  1  player/NPC collision, sampled each frame
- spawn_req  out  NUM_NPC  one-hot, one-frame spawn pulse
- spawn_x  out  10  start X for the granted slot, valid while spawn_req != 0
- spawn_dir  out  1  initial diagonal direction (1 = right), valid with spawn_req
- run  out  1  motion enable to all cars (1 only in RUN)
- clear_all  out  1  instructs all cars to despawn (1 in IDLE)
- level  out  4  difficulty level, saturates at 15
- spawn_count  out  16  total spawns since start, wraps at 65535→0

Behaviour:
- Reset (async): state=IDLE; spawn_req=0, spawn_x=0, spawn_dir=0, run=0, clear_all=1, level=0, spawn_count=0; interval=SPAWN_INIT; frame counter=0; rr pointer=0; last key=0.
- Key edge: an action fires only when keycode differs from the previous frame's keycode (holding a key acts once).
- IDLE: clear_all=1, run=0. Start edge (8'h15) → RUN next frame. On entry to RUN: counter=SPAWN_INIT, interval=SPAWN_INIT, level=0, spawn_count=0.
- RUN: run=1, clear_all=0. Counter decrements by 1 per frame while >0.
  - Counter==0 and an idle slot exists (npc_active bit 0): pulse spawn_req for exactly one frame on the first idle slot at or after rr+1 (mod NUM_NPC); rr←granted index; counter←interval; spawn_count+1.
  - Counter==0 and no idle slot: counter holds at 0; retry every frame; no pulse.
  - spawn_x = fold(randnum): r>NPC_X_MAX → 2·NPC_X_MAX−r; r<NPC_X_MIN → r+NPC_X_MIN; else r. Compute in 10 bits, zero-extended.
  - spawn_dir = randnum[0].
  - Level-up on the spawn that makes spawn_count a nonzero multiple of LEVEL_STEP: interval←max(interval−INTERVAL_STEP, SPAWN_MIN); level+1, saturating at 15.
- Pause edge (8'h13) in RUN → PAUSE; in PAUSE → RUN. PAUSE: run=0, counter frozen, no spawns, clear_all=0.
- collision=1 in RUN → CRASH. Collision has priority over a same-frame pause edge; a spawn due that frame is suppressed. collision is ignored outside RUN.
- CRASH: run=0, no spawns, frame counter counts CRASH_FRAMES frames, then → IDLE. Start key is ignored in CRASH.
- spawn_req is never asserted outside RUN. At most one bit is set per frame.

Optional Feature:
- Macro: NPC_SCHED_LANE_GUARD_EN.
- Defined: register last spawn_x. If |fold−last| < LANE_GUARD, use last+LANE_GUARD when that is ≤ NPC_X_MAX, otherwise last−LANE_GUARD. Clamp the result to [NPC_X_MIN, NPC_X_MAX]. last resets to 0.
- Undefined: spawn_x = fold(randnum) exactly; no extra register.

Decomposition:
- Package npc_pkg: state enum (IDLE, RUN, PAUSE, CRASH), KEY_START=8'h15, KEY_PAUSE=8'h13, X min/max constants, fold function.
- Sub-module npc_rr_pick: combinational round-robin one-hot picker (idle mask, last index → grant, any).

Test Plan:
- Reset then start key held 5 frames → one RUN entry; after 120 frames spawn_req=4'b0001, spawn_count=1, run=1.
- randnum=250 at spawn → spawn_x=214; randnum=10 → 58; randnum=100 → 100; spawn_dir=randnum[0].
- npc_active=4'b1111 when counter expires → no pulse, counter holds 0; drop to 4'b1011 → spawn_req=4'b0100 the same frame.
- 8 spawns → level=1, next interval 110; continue to level 9 → interval clamps at 30, level keeps rising.
- Pause edge mid-count at counter=50 → counter holds 50 for 200 frames; second pause edge → resumes from 50.
- collision in RUN → run=0 for 90 frames, then IDLE with clear_all=1; async reset mid-CRASH → IDLE immediately.

Source files
------------

// File: rtl/npc_spawn_scheduler_pkg.sv
// Shared types and helpers for the NPC spawn scheduler: game state
// encoding, key codes, default spawn-X window and the X fold used to
// map a raw random byte into the legal spawn window.
package npc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    CRASH = 2'd3
  } npc_state_e;

  localparam logic [7:0] KEY_START = 8'h15;
  localparam logic [7:0] KEY_PAUSE = 8'h13;

  localparam int X_MIN = 48;
  localparam int X_MAX = 232;

  // Reflect values above the window back off the right edge, shift values
  // below the window right by the window minimum, pass the rest through.
  function automatic logic [9:0] fold_x(input logic [7:0] r,
                                        input logic [9:0] x_min,
                                        input logic [9:0] x_max);
    logic [9:0] rz;
    rz = {2'b00, r};
    if (rz > x_max)
      return (x_max << 1) - rz;
    else if (rz < x_min)
      return rz + x_min;
    else
      return rz;
  endfunction

endpackage

// File: rtl/npc_spawn_scheduler_rr_pick.sv
// Round-robin one-hot picker: returns the first idle slot strictly after
// last_idx (wrapping), its index, and whether any slot was idle at all.
module npc_rr_pick #(
  parameter int NUM_NPC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_NPC-1:0] idle,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_NPC-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  // Scan slots last_idx+1 .. last_idx+NUM_NPC and keep the first idle one.
  always_comb begin : pick
    int k;
    k         = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 1; i <= NUM_NPC; i++) begin
      k = int'(last_idx) + i;
      if (k >= NUM_NPC) k = k - NUM_NPC;
      if (!any && idle[k]) begin
        any       = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/npc_spawn_scheduler.sv
// NPC traffic sequencer: run/pause/crash state machine, difficulty-scaled
// spawn pacing and round-robin slot grants sharing one random source.
// Optional lane guard enabled by defining NPC_SCHED_LANE_GUARD_EN: keeps a
// new spawn at least LANE_GUARD pixels away from the previous spawn X.
module npc_spawn_scheduler
  import npc_pkg::*;
#(
  parameter int NUM_NPC       = 4,
  parameter int NPC_X_MIN     = X_MIN,
  parameter int NPC_X_MAX     = X_MAX,
  parameter int SPAWN_INIT    = 120,
  parameter int SPAWN_MIN     = 30,
  parameter int INTERVAL_STEP = 10,
  parameter int LEVEL_STEP    = 8,
  parameter int CRASH_FRAMES  = 90
`ifdef NPC_SCHED_LANE_GUARD_EN
  ,
  parameter int LANE_GUARD    = 24
`endif
) (
  input  logic               frame_clk,
  input  logic               reset,
  input  logic [7:0]         keycode,
  input  logic [7:0]         randnum,
  input  logic [NUM_NPC-1:0] npc_active,
  input  logic               collision,
  output logic [NUM_NPC-1:0] spawn_req,
  output logic [9:0]         spawn_x,
  output logic               spawn_dir,
  output logic               run,
  output logic               clear_all,
  output logic [3:0]         level,
  output logic [15:0]        spawn_count
);

  localparam int IDX_W = $clog2(NUM_NPC);

  npc_state_e       state;
  logic [15:0]      cnt;
  logic [15:0]      interval;
  logic [7:0]       last_key;
  // rr_start is the slot the next search begins at (one past the last
  // grant), so the very first spawn after reset lands on slot 0.
  logic [IDX_W-1:0] rr_start;

  logic               key_edge, start_edge, pause_edge;
  logic [15:0]        new_count;
  logic               lvl_up;
  logic [15:0]        next_interval;
  logic [IDX_W-1:0]   last_idx, rr_next;
  logic [NUM_NPC-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [9:0]         fold_val;
  logic [9:0]         spawn_x_new;

  npc_rr_pick #(
    .NUM_NPC (NUM_NPC),
    .IDX_W   (IDX_W)
  ) u_pick (
    .idle      (~npc_active),
    .last_idx  (last_idx),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  assign fold_val = fold_x(randnum, 10'(NPC_X_MIN), 10'(NPC_X_MAX));

`ifdef NPC_SCHED_LANE_GUARD_EN
  // Push a too-close X one guard width away from the previous spawn,
  // preferring the right side, then clamp into the legal window.
  function automatic logic [9:0] lane_guard(input logic [9:0] f,
                                            input logic [9:0] last);
    logic signed [11:0] fs, ls, gd, mn, mx, d, c;
    fs = signed'({2'b00, f});
    ls = signed'({2'b00, last});
    gd = 12'(LANE_GUARD);
    mn = 12'(NPC_X_MIN);
    mx = 12'(NPC_X_MAX);
    d  = fs - ls;
    if (d < 0) d = -d;
    c = fs;
    if (d < gd) c = (ls + gd <= mx) ? ls + gd : ls - gd;
    if (c < mn) c = mn;
    else if (c > mx) c = mx;
    return c[9:0];
  endfunction

  // spawn_x only updates on a grant, so it already holds the previous spawn X.
  assign spawn_x_new = lane_guard(fold_val, spawn_x);
`else
  assign spawn_x_new = fold_val;
`endif

  // Key edge detection, spawn bookkeeping and difficulty step for this frame.
  always_comb begin
    key_edge   = (keycode != last_key);
    start_edge = key_edge && (keycode == KEY_START);
    pause_edge = key_edge && (keycode == KEY_PAUSE);
    new_count  = spawn_count + 16'd1;
    lvl_up     = (new_count != 16'd0) && ((new_count % 16'(LEVEL_STEP)) == 16'd0);
    next_interval = interval;
    if (lvl_up)
      next_interval = (interval >= 16'(SPAWN_MIN + INTERVAL_STEP)) ?
                      interval - 16'(INTERVAL_STEP) : 16'(SPAWN_MIN);
    last_idx = (rr_start == '0) ? IDX_W'(NUM_NPC - 1) : rr_start - 1'b1;
    rr_next  = (pick_idx == IDX_W'(NUM_NPC - 1)) ? '0 : pick_idx + 1'b1;
  end

  // Game state machine with registered outputs; spawn pulses last one frame.
  always_ff @(posedge frame_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      interval    <= 16'(SPAWN_INIT);
      last_key    <= '0;
      rr_start    <= '0;
      spawn_req   <= '0;
      spawn_x     <= '0;
      spawn_dir   <= 1'b0;
      run         <= 1'b0;
      clear_all   <= 1'b1;
      level       <= '0;
      spawn_count <= '0;
    end else begin
      last_key  <= keycode;
      spawn_req <= '0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state       <= RUN;
            cnt         <= 16'(SPAWN_INIT);
            interval    <= 16'(SPAWN_INIT);
            level       <= '0;
            spawn_count <= '0;
            run         <= 1'b1;
            clear_all   <= 1'b0;
          end
        end
        RUN: begin
          // Collision wins over a same-frame pause edge and any due spawn;
          // a pause edge likewise freezes the count before it decrements.
          if (collision) begin
            state <= CRASH;
            cnt   <= 16'(CRASH_FRAMES - 1);
            run   <= 1'b0;
          end else if (pause_edge) begin
            state <= PAUSE;
            run   <= 1'b0;
          end else if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (pick_any) begin
            spawn_req   <= pick_grant;
            spawn_x     <= spawn_x_new;
            spawn_dir   <= randnum[0];
            rr_start    <= rr_next;
            cnt         <= next_interval;
            interval    <= next_interval;
            spawn_count <= new_count;
            if (lvl_up && level != 4'd15) level <= level + 4'd1;
          end
        end
        PAUSE: begin
          if (pause_edge) begin
            state <= RUN;
            run   <= 1'b1;
          end
        end
        CRASH: begin
          if (cnt == 16'd0) begin
            state     <= IDLE;
            clear_all <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state     <= IDLE;
          run       <= 1'b0;
          clear_all <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npc_spawn_scheduler.sv
// Bench for npc_spawn_scheduler: behavioural game model compared every frame,
// plus directed literal checks of latency, folding, round-robin, pause,
// level-up and crash behaviour.
module tb_npc_spawn_scheduler;

  localparam int N = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_CRASH = 3;

  logic         frame_clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   keycode = '0;
  logic [7:0]   randnum = '0;
  logic [N-1:0] npc_active = '0;
  logic         collision = 1'b0;
  logic [N-1:0] spawn_req;
  logic [9:0]   spawn_x;
  logic         spawn_dir;
  logic         run;
  logic         clear_all;
  logic [3:0]   level;
  logic [15:0]  spawn_count;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 frame_clk = ~frame_clk;

  npc_spawn_scheduler #(.NUM_NPC(N)) dut (
    .frame_clk   (frame_clk),
    .reset       (reset),
    .keycode     (keycode),
    .randnum     (randnum),
    .npc_active  (npc_active),
    .collision   (collision),
    .spawn_req   (spawn_req),
    .spawn_x     (spawn_x),
    .spawn_dir   (spawn_dir),
    .run         (run),
    .clear_all   (clear_all),
    .level       (level),
    .spawn_count (spawn_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_mode = M_IDLE;
  int         m_wait = 0;
  int         m_gap = 120;
  int         m_level = 0;
  int         m_count = 0;
  int         m_next = 0;
  int         m_crash = 0;
  logic [7:0] m_prev_key = '0;
  logic [N-1:0] e_req = '0;
  int         e_x = 0;
  logic       e_dir = 1'b0;
`ifdef NPC_SCHED_LANE_GUARD_EN
  int         m_last_x = 0;
`endif

  function automatic int fold_m(int r);
    if (r > 232) return 464 - r;
    if (r < 48) return r + 48;
    return r;
  endfunction

  function automatic int lane_m(int f);
    int x;
    x = f;
`ifdef NPC_SCHED_LANE_GUARD_EN
    begin
      int d;
      d = (x > m_last_x) ? x - m_last_x : m_last_x - x;
      if (d < 24) x = (m_last_x + 24 <= 232) ? m_last_x + 24 : m_last_x - 24;
      if (x < 48) x = 48;
      if (x > 232) x = 232;
      m_last_x = x;
    end
`endif
    return x;
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE; m_wait = 0; m_gap = 120; m_level = 0; m_count = 0;
    m_next = 0; m_crash = 0; m_prev_key = '0; e_req = '0; e_x = 0; e_dir = 1'b0;
`ifdef NPC_SCHED_LANE_GUARD_EN
    m_last_x = 0;
`endif
  endfunction

  function automatic void model_step();
    logic edge_k;
    int   s;
    bit   found;
    edge_k = (keycode != m_prev_key);
    m_prev_key = keycode;
    e_req = '0;
    case (m_mode)
      M_IDLE: if (edge_k && keycode == 8'h15) begin
        m_mode = M_RUN; m_wait = 120; m_gap = 120; m_level = 0; m_count = 0;
      end
      M_RUN: begin
        if (collision) begin
          m_mode = M_CRASH; m_crash = 90;
        end else if (edge_k && keycode == 8'h13) begin
          m_mode = M_PAUSE;
        end else if (m_wait > 0) begin
          m_wait--;
        end else begin
          found = 0; s = 0;
          for (int k = 0; k < N; k++)
            if (!found && !npc_active[(m_next + k) % N]) begin
              found = 1; s = (m_next + k) % N;
            end
          if (found) begin
            e_req[s] = 1'b1;
            e_x = lane_m(fold_m(int'(randnum)));
            e_dir = randnum[0];
            m_next = (s + 1) % N;
            m_count = (m_count + 1) % 65536;
            if (m_count != 0 && m_count % 8 == 0) begin
              m_gap = (m_gap - 10 < 30) ? 30 : m_gap - 10;
              if (m_level < 15) m_level++;
            end
            m_wait = m_gap;
          end
        end
      end
      M_PAUSE: if (edge_k && keycode == 8'h13) m_mode = M_RUN;
      default: begin
        m_crash--;
        if (m_crash == 0) m_mode = M_IDLE;
      end
    endcase
  endfunction

  // Advance the model on every frame edge and compare shortly after it.
  always @(posedge frame_clk) begin
    if (reset) model_reset();
    else model_step();
    #2;
    chk("spawn_req", spawn_req, e_req);
    chk("run", run, m_mode == M_RUN);
    chk("clear_all", clear_all, m_mode == M_IDLE);
    chk("level", level, m_level);
    chk("spawn_count", spawn_count, m_count);
    if (e_req != '0) begin
      chk("spawn_x", spawn_x, e_x);
      chk("spawn_dir", spawn_dir, e_dir);
    end
  end

  task automatic wait_spawn(input int limit, output int n);
    n = 0;
    do begin
      @(negedge frame_clk);
      n++;
    end while (spawn_req == '0 && n < limit);
    if (spawn_req == '0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL spawn_wait: no spawn_req within %0d frames", limit);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    chk("model_fold_250", fold_m(250), 214);
    chk("model_fold_10", fold_m(10), 58);
    chk("model_fold_100", fold_m(100), 100);

    repeat (2) @(negedge frame_clk);
    reset = 1'b0;
    chk("rst_spawn_req", spawn_req, 0);
    chk("rst_run", run, 0);
    chk("rst_clear_all", clear_all, 1);
    chk("rst_level", level, 0);
    chk("rst_count", spawn_count, 0);
    chk("rst_spawn_x", spawn_x, 0);

    // Start key held for five frames acts once; first spawn on slot 0.
    randnum = 8'd250;
    keycode = 8'h15;
    repeat (5) @(negedge frame_clk);
    keycode = 8'h00;
    wait_spawn(200, n);
    chk("first_spawn_latency", 5 + n, 122);
    chk("first_req", spawn_req, 4'b0001);
    chk("first_count", spawn_count, 1);
    chk("first_run", run, 1);
    chk("x_250", spawn_x, 214);
    chk("dir_250", spawn_dir, 0);

    randnum = 8'd10;
    npc_active = 4'b0001;
    wait_spawn(200, n);
    chk("gap_120", n, 121);
    chk("req_slot1", spawn_req, 4'b0010);
    chk("x_10", spawn_x, 58);

    randnum = 8'd100;
    npc_active = 4'b0000;
    wait_spawn(200, n);
    chk("req_slot2", spawn_req, 4'b0100);
    chk("x_100", spawn_x, 100);
    chk("dir_100", spawn_dir, 0);

    // All slots busy: hold and retry; release slot 2 -> grant the next frame.
    randnum = 8'd77;
    npc_active = 4'b1111;
    repeat (130) @(negedge frame_clk);
    chk("busy_no_req", spawn_req, 0);
    chk("busy_count", spawn_count, 3);
    npc_active = 4'b1011;
    @(negedge frame_clk);
    chk("retry_req", spawn_req, 4'b0100);
    chk("retry_count", spawn_count, 4);
    chk("x_77", spawn_x, 77);
    chk("dir_77", spawn_dir, 1);

    // Pause when the counter reads 50, hold 200 frames, resume from 50.
    npc_active = 4'b0000;
    repeat (70) @(negedge frame_clk);
    keycode = 8'h13;
    @(negedge frame_clk);
    chk("pause_run", run, 0);
    chk("pause_clear", clear_all, 0);
    repeat (99) @(negedge frame_clk);
    keycode = 8'h00;
    repeat (100) @(negedge frame_clk);
    chk("pause_count", spawn_count, 4);
    keycode = 8'h13;
    @(negedge frame_clk);
    chk("resume_run", run, 1);
    wait_spawn(200, n);
    chk("resume_gap", n, 51);
    keycode = 8'h00;

    // Spawns 6..8 complete level 1; the next gap uses interval 110.
    repeat (3) wait_spawn(200, n);
    chk("lvl1_level", level, 1);
    chk("lvl1_count", spawn_count, 8);
    wait_spawn(200, n);
    chk("lvl1_gap", n, 111);

    // Randomized traffic until level 10; interval must then sit at 30.
    n = 0;
    while (level < 4'd10 && n < 30000) begin
      randnum = 8'($urandom);
      npc_active = N'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) npc_active = '1;
      @(negedge frame_clk);
      n++;
    end
    chk("reach_level10", level >= 4'd10, 1);
    npc_active = '0;
    wait_spawn(400, n);
    wait_spawn(400, n);
    chk("clamped_gap", n, 31);

    // Randomized keys and collisions against the model.
    for (int i = 0; i < 3000; i++) begin
      randnum = 8'($urandom);
      npc_active = N'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0)
        case ($urandom_range(0, 3))
          0: keycode = 8'h00;
          1: keycode = 8'h13;
          2: keycode = 8'h15;
          default: keycode = 8'h2A;
        endcase
      collision = ($urandom_range(0, 59) == 0);
      @(negedge frame_clk);
    end
    collision = 1'b0;
    keycode = 8'h00;

    // Directed crash: 90 frames frozen, start key ignored, then IDLE.
    reset = 1'b1;
    @(negedge frame_clk);
    reset = 1'b0;
    npc_active = '0;
    keycode = 8'h15;
    @(negedge frame_clk);
    keycode = 8'h00;
    chk("crash_pre_run", run, 1);
    repeat (10) @(negedge frame_clk);
    collision = 1'b1;
    @(negedge frame_clk);
    collision = 1'b0;
    chk("crash_run", run, 0);
    chk("crash_clear", clear_all, 0);
    keycode = 8'h15;
    repeat (5) @(negedge frame_clk);
    keycode = 8'h00;
    repeat (84) @(negedge frame_clk);
    chk("crash_90_clear", clear_all, 0);
    chk("crash_90_run", run, 0);
    @(negedge frame_clk);
    chk("crash_idle_clear", clear_all, 1);

    // Async reset in the middle of a crash returns to IDLE at once.
    keycode = 8'h15;
    @(negedge frame_clk);
    keycode = 8'h00;
    repeat (3) @(negedge frame_clk);
    collision = 1'b1;
    @(negedge frame_clk);
    collision = 1'b0;
    repeat (10) @(negedge frame_clk);
    chk("midcrash_clear", clear_all, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_clear", clear_all, 1);
    chk("async_run", run, 0);
    chk("async_level", level, 0);
    chk("async_count", spawn_count, 0);
    @(negedge frame_clk);
    reset = 1'b0;
    repeat (3) @(negedge frame_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
